// File: rtl/pool_out_if.sv
// pool_out_if: bundles both streams of the pooling stage.
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high. A source keeps valid, data and last steady until that edge,
// and never waits on ready before raising valid. A sink may raise or drop
// ready freely.
//
// Signals:
//   s_valid/s_ready/s_data         input stream, two signed 32-bit words per beat
//   m_valid/m_ready/m_data/m_last  output stream, two pooled words per beat
//
// Modports:
//   slave  - the pooling stage (sink of s_*, source of m_*)
//   master - the surrounding system (source of s_*, sink of m_*)
interface pool_out_if;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/pool_out.sv
// pool_out: optional ReLU plus 2x2 stride-2 max pooling on a 64-bit result
// stream carrying two horizontally adjacent signed 32-bit columns per beat.
//
// Ports:
//   clk      single clock
//   reset    synchronous, active-high
//   relu_en  clamp negatives to zero; held constant for a whole frame
//   io       pool_out_if.slave: s_* input stream, m_* output stream
//   idle     high when both counters are zero and no output beat is held
//
// Parameters: W = input row width in 32-bit words (multiple of 4),
//             H = rows per frame (even).
module pool_out #(
  parameter int W = 16,
  parameter int H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       relu_en,
  pool_out_if.slave  io,
  output logic       idle
);

  localparam int NB  = W / 2;
  localparam int CBW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;

  logic [CBW-1:0]     cb;
  logic [RW-1:0]      r;
  logic signed [31:0] pend;
  logic [63:0]        m_data_q;
  logic               m_valid_q;
  logic               m_last_q;

  // Distributed line buffer with combinational read: even rows only write,
  // odd rows only read, so one entry is never read and written together.
  logic signed [31:0] lbuf [NB];

  logic signed [31:0] col_lo, col_hi, h_pair, h, lb, v;
  logic odd_row, odd_col, row_end, frame_end;
  logic ready, fire, load;

  always_comb begin
    col_lo = io.s_data[31:0];
    col_hi = io.s_data[63:32];
    h_pair = (col_lo > col_hi) ? col_lo : col_hi;
    h      = (relu_en && h_pair < 0) ? 32'sd0 : h_pair;
    lb     = lbuf[cb];
    v      = (lb > h) ? lb : h;
  end

  assign odd_row   = r[0];
  assign odd_col   = cb[0];
  assign row_end   = (cb == CBW'(NB - 1));
  assign frame_end = (r == RW'(H - 1));

  // Only the beat that completes a 2x2 pair of windows needs the output
  // register, so only that beat can be back-pressured.
  assign ready = (odd_row && odd_col) ? (~m_valid_q | io.m_ready) : 1'b1;
  assign fire  = io.s_valid & ready;
  assign load  = fire & odd_row & odd_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      cb        <= '0;
      r         <= '0;
      pend      <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      // Drain first; a load in the same cycle overrides below.
      if (m_valid_q && io.m_ready) m_valid_q <= 1'b0;
      if (fire) begin
        if (row_end) begin
          cb <= '0;
          r  <= frame_end ? '0 : r + 1'b1;
        end else begin
          cb <= cb + 1'b1;
        end
        if (odd_row && !odd_col) pend <= v;
        if (load) begin
          m_data_q  <= {v, pend};
          m_valid_q <= 1'b1;
          m_last_q  <= frame_end && row_end;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire && !odd_row) lbuf[cb] <= h;
  end

  assign io.s_ready = ready;
  assign io.m_valid = m_valid_q;
  assign io.m_data  = m_data_q;
  assign io.m_last  = m_last_q;
  assign idle       = (cb == '0) && (r == '0) && !m_valid_q;

endmodule
